// File: rtl/game_scorer.sv
// Target/button scoring game: arm a target, score hits on presses, count misses, decide win/lose.
// Optional build macro SCORER_STREAK_EN adds a 2-bit hit streak that doubles the increment at streak 3.
module game_scorer #(
    parameter int unsigned N_TARGETS  = 8,
    parameter int unsigned WIN_SCORE  = 10,
    parameter int unsigned MAX_MISSES = 3,
    parameter int unsigned SCORE_W    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         target_load,
    input  logic [$clog2(N_TARGETS)-1:0] placement,
    input  logic [N_TARGETS-1:0]         buttonin,
    input  logic                         instLoss,
    output logic [SCORE_W-1:0]           score,
    output logic [3:0]                   misses,
    output logic [1:0]                   winlose,
    output logic                         hit_pulse,
    output logic                         armed
);

    localparam int unsigned PW = $clog2(N_TARGETS);
    localparam int unsigned AW = SCORE_W + 1;

    typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

    state_t               state_q, state_d;
    logic [N_TARGETS-1:0] buttonin_q;
    logic [N_TARGETS-1:0] press_q;
    logic [PW-1:0]        target_q, target_d;
    logic [SCORE_W-1:0]   score_d;
    logic [3:0]           misses_d;
    logic [1:0]           winlose_d;
    logic                 hit_d;
    logic                 armed_d;

    logic [AW-1:0]        inc;
    logic [AW-1:0]        score_sum;
    logic [N_TARGETS-1:0] target_mask;
    logic                 is_hit;
    logic                 is_miss;
    logic                 load_ok;

`ifdef SCORER_STREAK_EN
    logic [1:0] streak_q, streak_d;
    assign inc = (streak_q == 2'd3) ? AW'(2) : AW'(1);
`else
    assign inc = AW'(1);
`endif

    // Press set is judged against the target that was armed before any same-cycle load
    assign target_mask = N_TARGETS'(1) << target_q;
    assign is_hit      = armed && (press_q == target_mask);
    assign is_miss     = (|press_q) && !is_hit;
    assign score_sum   = AW'(score) + inc;
    assign load_ok     = {1'b0, placement} < (PW + 1)'(N_TARGETS);

    always_comb begin
        state_d   = state_q;
        score_d   = score;
        misses_d  = misses;
        armed_d   = armed;
        target_d  = target_q;
        hit_d     = 1'b0;
`ifdef SCORER_STREAK_EN
        streak_d  = streak_q;
`endif
        unique case (state_q)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    state_d  = PLAY;
                    score_d  = '0;
                    misses_d = '0;
                    armed_d  = 1'b0;
`ifdef SCORER_STREAK_EN
                    streak_d = '0;
`endif
                end
            end
            PLAY: begin
                if (instLoss) begin
                    state_d = LOSE;
                end else begin
                    if (AW'(score) >= AW'(WIN_SCORE)) begin
                        state_d = WIN;
                    end else if (misses >= 4'(MAX_MISSES)) begin
                        state_d = LOSE;
                    end
                    if (is_hit) begin
                        score_d = (score_sum >= AW'(WIN_SCORE)) ? SCORE_W'(WIN_SCORE)
                                                                 : score_sum[SCORE_W-1:0];
                        hit_d   = 1'b1;
                        armed_d = 1'b0;
`ifdef SCORER_STREAK_EN
                        streak_d = (streak_q == 2'd3) ? streak_q : streak_q + 2'd1;
`endif
                    end else if (is_miss) begin
                        misses_d = (misses == 4'hf) ? misses : misses + 4'd1;
`ifdef SCORER_STREAK_EN
                        streak_d = '0;
`endif
                    end
                    if (target_load && load_ok) begin
                        armed_d  = 1'b1;
                        target_d = placement;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        winlose_d = 2'b00;
        if (state_d == WIN)  winlose_d = 2'b10;
        if (state_d == LOSE) winlose_d = 2'b01;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            score      <= '0;
            misses     <= '0;
            winlose    <= 2'b00;
            hit_pulse  <= 1'b0;
            armed      <= 1'b0;
            target_q   <= '0;
            buttonin_q <= buttonin;
            press_q    <= '0;
`ifdef SCORER_STREAK_EN
            streak_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            score      <= score_d;
            misses     <= misses_d;
            winlose    <= winlose_d;
            hit_pulse  <= hit_d;
            armed      <= armed_d;
            target_q   <= target_d;
            buttonin_q <= buttonin;
            press_q    <= buttonin & ~buttonin_q;
`ifdef SCORER_STREAK_EN
            streak_q   <= streak_d;
`endif
        end
    end

endmodule

// File: doc/game_scorer.md
GAME_SCORER -- requirements
Module: game_scorer

Interface
REQ-001 SHALL have parameter N_TARGETS, default 8, meaning the number of buttons/targets (2..16).
REQ-002 SHALL have parameter WIN_SCORE, default 10, meaning the score that triggers a win (1..2^SCORE_W-1).
REQ-003 SHALL have parameter MAX_MISSES, default 3, meaning the miss count that triggers a loss (1..15).
REQ-004 SHALL have parameter SCORE_W, default 4, meaning the score width in bits.
REQ-005 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, a pulse that starts a game from IDLE, WIN or LOSE.
REQ-008 SHALL have port target_load, input, 1, a pulse that arms the target at placement.
REQ-009 SHALL have port placement, input, clog2(N_TARGETS), the index of the target to arm.
REQ-010 SHALL have port buttonin, input, N_TARGETS, level button inputs, already debounced.
REQ-011 SHALL have port instLoss, input, 1, a level that forces an immediate loss.
REQ-012 SHALL have port score, output, SCORE_W, the current score.
REQ-013 SHALL have port misses, output, 4, the current miss count.
REQ-014 SHALL have port winlose, output, 2: bit1 = win, bit0 = lose.
REQ-015 SHALL have port hit_pulse, output, 1, a one-cycle pulse on each scored hit.
REQ-016 SHALL have port armed, output, 1, high while a target is armed.

Function
REQ-017 SHALL implement FSM states IDLE, PLAY, WIN and LOSE.
- IDLE/WIN/LOSE -> PLAY on start.
- PLAY -> WIN when score >= WIN_SCORE.
- PLAY -> LOSE on instLoss or when misses == MAX_MISSES.
REQ-018 SHALL clear score, misses, armed and the streak on every transition into PLAY.
REQ-019 SHALL register buttonin once; a press = rising edge (buttonin & ~buttonin_q); a held button counts once.
REQ-020 SHALL, in PLAY with armed=1, treat a press set of exactly the armed bit as a hit: score+increment, hit_pulse=1 next cycle, armed cleared.
REQ-021 SHALL, in PLAY, count as one miss (misses+1, saturating at 15) a press set containing any unarmed bit, or any press while armed=0; the armed target stays armed.
REQ-022 SHALL update score, misses and hit_pulse registered, one cycle after the press edge is detected (two cycles after the buttonin change).
REQ-023 SHALL saturate score at WIN_SCORE; arithmetic is internally SCORE_W+1 bits wide, no wrap.
REQ-024 SHALL, on target_load in PLAY, set armed=1 and latch placement; a load while already armed replaces the target with no miss; placement >= N_TARGETS is ignored.
REQ-025 SHALL let a same-cycle target_load and press be judged against the previous armed target, with the load taking effect afterwards.
REQ-026 SHALL give instLoss priority over a same-cycle hit or miss: that hit does not score, state -> LOSE.
REQ-027 SHALL drive winlose = 2'b10 in WIN, 2'b01 in LOSE and 2'b00 otherwise; in WIN/LOSE score and misses freeze and presses are ignored.
REQ-028 SHALL, when a hit reaches WIN_SCORE in the same cycle as misses reaches MAX_MISSES, resolve to WIN.

Reset
REQ-029 SHALL, on reset, set state=IDLE, score=0, misses=0, winlose=2'b00, hit_pulse=0, armed=0, streak=0 and buttonin_q=buttonin.
REQ-030 SHALL let reset mid-game override all other inputs in the same cycle.

Configuration
REQ-031 SHALL, with SCORER_STREAK_EN defined, keep a 2-bit saturating hit streak (cleared by a miss): increment=2 when the streak is 3 before the hit, else 1.
REQ-032 SHALL, without SCORER_STREAK_EN, use increment 1 always and instantiate no streak logic.

Verification
REQ-033 SHALL cover: reset, start, load idx 3, press bit 3 -> score=1, hit_pulse one cycle, armed=0.
REQ-034 SHALL cover: load idx 2, press bit 5 -> misses=1, score=0, armed stays 1; three wrong presses -> winlose=2'b01.
REQ-035 SHALL cover: 10 correct load/press pairs (macro off) -> score=10, winlose=2'b10; further presses leave score=10.
REQ-036 SHALL cover: instLoss asserted in the same cycle as a correct press at score 9 -> score=9, winlose=2'b01.
REQ-037 SHALL cover: with SCORER_STREAK_EN defined, 4 consecutive hits -> score 1,2,3,5; a miss then a hit -> +1.
REQ-038 SHALL cover: a button held 20 cycles -> exactly one hit; reset mid-PLAY -> all outputs 0, state IDLE.
